// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave memory responder: terminates one slave port with an internal word memory.
// Write and read paths are independent FSMs, each with one transaction in flight.
module axi_slave_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int SIZE_LOG = $clog2(BYTES);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic {R_IDLE, R_DATA} rState_t;

    function automatic logic [ADDR_WIDTH-1:0] wordOf(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> SIZE_LOG;
    endfunction

    // Addresses below BASE_ADDR wrap to huge word indices and so land out of range too.
    function automatic logic addrErr(input logic [ADDR_WIDTH-1:0] a);
        return wordOf(a) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] memIdx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(wordOf(a));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] alignAddr(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(BYTES - 1);
    endfunction

    function automatic logic cfgErr(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'(SIZE_LOG)) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Holds the ready signals low through the first clock after reset release.
    logic r_active;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_active <= 1'b0;
        else        r_active <= 1'b1;
    end

    wState_t               r_wState, w_wNext;
    logic [ID_WIDTH-1:0]   r_awId;
    logic [ADDR_WIDTH-1:0] r_wAddr;
    logic [7:0]            r_awLen;
    logic [7:0]            r_wBeat;
    logic [1:0]            r_awBurst;
    logic                  r_awCfgErr;
    logic                  r_wErr;
    logic                  r_wPastLen;
    logic                  w_wHs;
    logic                  w_wBeatErr;
    logic                  w_wLastErr;
    logic                  w_wWrEn;
    logic [IDX_W-1:0]      w_wIdx;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_wState <= W_IDLE;
        else        r_wState <= w_wNext;
    end

    always_comb begin
        w_wNext = r_wState;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (r_wState)
            W_IDLE: begin
                AWREADY = r_active;
                if (AWVALID && r_active) w_wNext = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && WLAST) w_wNext = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_wNext = W_IDLE;
            end
            default: w_wNext = W_IDLE;
        endcase
    end

    assign w_wHs      = WVALID && WREADY;
    assign w_wBeatErr = r_awCfgErr || addrErr(r_wAddr);
    assign w_wLastErr = WLAST ? (r_wPastLen || (r_wBeat != r_awLen))
                              : (!r_wPastLen && (r_wBeat == r_awLen));
    assign w_wWrEn    = w_wHs && !w_wBeatErr && !r_wPastLen;
    assign w_wIdx     = memIdx(r_wAddr);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awId     <= '0;
            r_wAddr    <= '0;
            r_awLen    <= '0;
            r_wBeat    <= '0;
            r_awBurst  <= '0;
            r_awCfgErr <= 1'b0;
            r_wErr     <= 1'b0;
            r_wPastLen <= 1'b0;
        end else if (AWVALID && AWREADY) begin
            r_awId     <= AWID;
            r_wAddr    <= alignAddr(AWADDR);
            r_awLen    <= AWLEN;
            r_wBeat    <= '0;
            r_awBurst  <= AWBURST;
            r_awCfgErr <= cfgErr(AWSIZE, AWBURST);
            r_wErr     <= 1'b0;
            r_wPastLen <= 1'b0;
        end else if (w_wHs) begin
            r_wBeat <= r_wBeat + 8'd1;
            r_wErr  <= r_wErr || w_wBeatErr || w_wLastErr;
            if (r_awBurst == BURST_INCR) r_wAddr <= r_wAddr + ADDR_WIDTH'(BYTES);
            if (!WLAST && (r_wBeat == r_awLen)) r_wPastLen <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_wWrEn) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) r_mem[w_wIdx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    assign BID   = r_awId;
    assign BRESP = (BVALID && r_wErr) ? RESP_SLVERR : RESP_OKAY;

    rState_t               r_rState, w_rNext;
    logic [ID_WIDTH-1:0]   r_arId;
    logic [ADDR_WIDTH-1:0] r_rAddr;
    logic [7:0]            r_arLen;
    logic [7:0]            r_rBeat;
    logic [1:0]            r_arBurst;
    logic                  r_arCfgErr;
    logic [DATA_WIDTH-1:0] r_rData;
    logic [1:0]            r_rResp;
    logic                  r_rLast;
    logic                  w_rLoad;
    logic [ADDR_WIDTH-1:0] w_rLoadAddr;
    logic [7:0]            w_rLoadBeat;
    logic [7:0]            w_rLoadLen;
    logic                  w_rLoadErr;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_rState <= R_IDLE;
        else        r_rState <= w_rNext;
    end

    always_comb begin
        w_rNext = r_rState;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (r_rState)
            R_IDLE: begin
                ARREADY = r_active;
                if (ARVALID && r_active) w_rNext = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && r_rLast) w_rNext = R_IDLE;
            end
            default: w_rNext = R_IDLE;
        endcase
    end

    // The beat register is loaded on the AR handshake and on every non-final R handshake,
    // so the next beat is presented without a bubble and stays frozen while stalled.
    assign w_rLoad     = (ARVALID && ARREADY) || (RVALID && RREADY && !r_rLast);
    assign w_rLoadAddr = (r_rState == R_IDLE) ? alignAddr(ARADDR)
                       : ((r_arBurst == BURST_INCR) ? r_rAddr + ADDR_WIDTH'(BYTES) : r_rAddr);
    assign w_rLoadBeat = (r_rState == R_IDLE) ? 8'd0 : r_rBeat + 8'd1;
    assign w_rLoadLen  = (r_rState == R_IDLE) ? ARLEN : r_arLen;
    assign w_rLoadErr  = ((r_rState == R_IDLE) ? cfgErr(ARSIZE, ARBURST) : r_arCfgErr)
                       || addrErr(w_rLoadAddr);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arId     <= '0;
            r_rAddr    <= '0;
            r_arLen    <= '0;
            r_rBeat    <= '0;
            r_arBurst  <= '0;
            r_arCfgErr <= 1'b0;
            r_rData    <= '0;
            r_rResp    <= RESP_OKAY;
            r_rLast    <= 1'b0;
        end else begin
            if (ARVALID && ARREADY) begin
                r_arId     <= ARID;
                r_arLen    <= ARLEN;
                r_arBurst  <= ARBURST;
                r_arCfgErr <= cfgErr(ARSIZE, ARBURST);
            end
            if (w_rLoad) begin
                r_rAddr <= w_rLoadAddr;
                r_rBeat <= w_rLoadBeat;
                r_rLast <= (w_rLoadBeat == w_rLoadLen);
                r_rResp <= w_rLoadErr ? RESP_SLVERR : RESP_OKAY;
                r_rData <= w_rLoadErr ? '0 : r_mem[memIdx(w_rLoadAddr)];
            end else if (RVALID && RREADY) begin
                r_rLast <= 1'b0;
            end
        end
    end

    assign RID   = r_arId;
    assign RDATA = r_rData;
    assign RRESP = r_rResp;
    assign RLAST = r_rLast;

endmodule
